// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding and framebuffer defaults for draw_arbiter
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BG_RUN   = 2'd1,
        BG_FLUSH = 2'd2
    } state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int COLOUR_W     = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - two-requester sprite arbiter; RR_ARB_EN selects round-robin, else requester 0 wins
module rr_arbiter
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef RR_ARB_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif

    // ptr=1 gives requester 1 the win on the next contention
    logic ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr <= ROTATE & grant[0];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (en && resetn) begin
            if (req == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - background ROM loader plus sprite pixel arbitration into one plot port
// RR_ARB_EN: round-robin sprite arbitration (default build: fixed priority, requester 0 first)
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  transition,
    input  logic [3:0]            location,
    output logic [3:0]            rom_sel,
    output logic [14:0]           rom_addr,
    input  logic [COLOUR_W-1:0]   rom_data,
    input  logic [1:0]            spr_req,
    input  logic [15:0]           spr_x,
    input  logic [13:0]           spr_y,
    input  logic [2*COLOUR_W-1:0] spr_colour,
    output logic [1:0]            spr_grant,
    output logic                  plot,
    output logic [7:0]            x,
    output logic [6:0]            y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  busy,
    output logic                  bg_done
);

    state_t              state;
    logic                trans_q;
    logic [7:0]          cnt_x;
    logic [6:0]          cnt_y;
    logic                pipe_v;
    logic [7:0]          pipe_x;
    logic [6:0]          pipe_y;
    logic                start;
    logic                last_col;
    logic                last_pix;
    logic [7:0]          spr_px;
    logic [6:0]          spr_py;
    logic [COLOUR_W-1:0] spr_pc;

    assign start    = transition & ~trans_q;
    assign last_col = (cnt_x == 8'(SCREEN_W - 1));
    assign last_pix = last_col && (cnt_y == 7'(SCREEN_H - 1));

    // A load start claims the cycle, so sprites only compete in quiet IDLE cycles
    rr_arbiter u_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     ((state == IDLE) && !start),
        .req    (spr_req),
        .grant  (spr_grant)
    );

    always_comb begin
        spr_px = spr_x[7:0];
        spr_py = spr_y[6:0];
        spr_pc = spr_colour[COLOUR_W-1:0];
        if (spr_grant[1]) begin
            spr_px = spr_x[15:8];
            spr_py = spr_y[13:7];
            spr_pc = spr_colour[2*COLOUR_W-1:COLOUR_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            trans_q  <= 1'b0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            rom_sel  <= '0;
            rom_addr <= '0;
            pipe_v   <= 1'b0;
            pipe_x   <= '0;
            pipe_y   <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            busy     <= 1'b0;
            bg_done  <= 1'b0;
        end else begin
            trans_q <= transition;
            bg_done <= 1'b0;
            pipe_v  <= 1'b0;

            // pipe_x/pipe_y line up with rom_data, which trails rom_addr by one cycle
            if (pipe_v) begin
                plot   <= 1'b1;
                x      <= pipe_x;
                y      <= pipe_y;
                colour <= rom_data;
            end else if (spr_grant != 2'b00) begin
                plot   <= 1'b1;
                x      <= spr_px;
                y      <= spr_py;
                colour <= spr_pc;
            end else begin
                plot   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rom_sel  <= location;
                        cnt_x    <= '0;
                        cnt_y    <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        state    <= BG_RUN;
                    end
                end
                BG_RUN: begin
                    pipe_v <= 1'b1;
                    pipe_x <= cnt_x;
                    pipe_y <= cnt_y;
                    if (start) begin
                        rom_sel  <= location;
                        cnt_x    <= '0;
                        cnt_y    <= '0;
                        rom_addr <= '0;
                    end else if (last_pix) begin
                        state <= BG_FLUSH;
                    end else begin
                        rom_addr <= rom_addr + 15'd1;
                        if (last_col) begin
                            cnt_x <= '0;
                            cnt_y <= cnt_y + 7'd1;
                        end else begin
                            cnt_x <= cnt_x + 8'd1;
                        end
                    end
                end
                BG_FLUSH: begin
                    busy    <= 1'b0;
                    bg_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning framebuffer height in pixels.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port transition  in  1  navigation wait-state flag; the rising edge requests a background load.
REQ-006 SHALL have port location  in  4  navigation location code, latched at load start.
REQ-007 SHALL have port rom_sel  out  4  latched location; selects the background ROM bank.
REQ-008 SHALL have port rom_addr  out  15  background ROM address, y*SCREEN_W+x.
REQ-009 SHALL have port rom_data  in  3  ROM colour, valid one cycle after rom_addr.
REQ-010 SHALL have port spr_req  in  2  per-sprite pixel request, held until granted.
REQ-011 SHALL have port spr_x  in  16  two 8-bit x coordinates, requester 0 in the low bits.
REQ-012 SHALL have port spr_y  in  14  two 7-bit y coordinates.
REQ-013 SHALL have port spr_colour  in  6  two 3-bit colours.
REQ-014 SHALL have port spr_grant  out  2  one-hot; the pixel is consumed in the cycle it is high.
REQ-015 SHALL have port plot  out  1  framebuffer write enable.
REQ-016 SHALL have port x  out  8, y  out  7, colour  out  3  write pixel.
REQ-017 SHALL have port busy  out  1  high while a background load is in progress.
REQ-018 SHALL have port bg_done  out  1  single-cycle pulse when a load completes.

Function
REQ-019 SHALL implement states IDLE, BG_RUN and BG_FLUSH.
REQ-020 In IDLE, on transition sampled high with the previous sample low, SHALL latch location into rom_sel, clear the x,y counters and enter BG_RUN.
REQ-021 In BG_RUN, SHALL present rom_addr for (x,y) each cycle and advance x; at x=SCREEN_W-1, SHALL wrap x to 0 and increment y.
REQ-022 SHALL, one cycle after issuing rom_addr for (x,y), drive plot=1 with that x,y and colour=rom_data.
REQ-023 After issuing (SCREEN_W-1,SCREEN_H-1), SHALL enter BG_FLUSH for one cycle (last plot), then return to IDLE and pulse bg_done in that first IDLE cycle.
REQ-024 SHALL hold busy high in BG_RUN and BG_FLUSH.
REQ-025 SHALL, on a transition rising edge during BG_RUN, re-latch location and restart at (0,0); the in-flight pixel still plots.
REQ-026 SHALL give the background absolute priority: spr_grant=0 in BG_RUN and BG_FLUSH.
REQ-027 In IDLE, SHALL grant at most one requester per cycle; the granted pixel drives plot/x/y/colour on the next cycle.
REQ-028 SHALL grant nothing, and drive plot=0 on the next cycle, when spr_req=0.
REQ-029 SHALL give a transition edge precedence over sprite requests in the same IDLE cycle: no grant in that cycle.

Reset
REQ-030 SHALL, while resetn=0, force state IDLE, counters 0, rom_sel 0, rom_addr 0, spr_grant 0, plot 0, x 0, y 0, colour 0, busy 0, bg_done 0, edge-detect register 0 and round-robin pointer 0.
REQ-031 SHALL discard any load aborted by reset; no plot occurs after reset asserts.

Configuration
REQ-032 With RR_ARB_EN defined, SHALL arbitrate sprites round-robin: after granting requester i, requester 1-i wins the next contention.
REQ-033 Without RR_ARB_EN, SHALL use fixed priority, with requester 0 always winning contention.

Structure
REQ-034 SHALL place the state enum, SCREEN_W/SCREEN_H defaults and colour width in shared package draw_pkg.
REQ-035 SHALL implement sprite arbitration in sub-module rr_arbiter (2 requesters; priority pointer compiled per RR_ARB_EN).

Verification
REQ-036 SHALL verify: reset, then transition 0->1 with location=1 -> rom_sel=1, first plot at (0,0) two cycles after the edge sample, exactly 19200 plots, then a bg_done pulse.
REQ-037 SHALL verify: rom_data driven as addr[2:0] -> every plotted colour equals (y*160+x)[2:0]; x wraps 159->0 and y increments.
REQ-038 SHALL verify: spr_req=2'b11 held in IDLE -> grants alternate 01,10,01 with RR_ARB_EN, and stay 01 without it.
REQ-039 SHALL verify: spr_req=2'b01 during BG_RUN -> no grant until load ends; grant in the first IDLE cycle after bg_done.
REQ-040 SHALL verify: a second transition edge at pixel 5000 -> restart at (0,0) with the new rom_sel; exactly 19200 further plots.
REQ-041 SHALL verify: resetn low at pixel 100 -> plot=0 immediately, busy=0, no bg_done.
